// File: rtl/count_seg_display.sv
// Two-digit multiplexed 7-segment display of a captured 4-bit count, with 15->0 wrap counting.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens slot when the tens digit is zero.
module count_seg_display #(
    parameter int unsigned REFRESH_DIV    = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] count_in,
    input  logic       count_valid,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap_pulse,
    output logic [7:0] wrap_cnt
);

    localparam int unsigned    PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]     AN_OFF     = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        SHOW_ONES,
        BLANK_A,
        SHOW_TENS,
        BLANK_B
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    held_q, held_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          wrap_pulse_q, wrap_pulse_d;
    logic [7:0]    wrap_cnt_q, wrap_cnt_d;

    logic          wrap_hit;
    logic          tens;
    logic [3:0]    ones;
    logic [6:0]    seg_hi;
    logic [1:0]    an_hi;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h3F;
            4'd1:    c = 7'h06;
            4'd2:    c = 7'h5B;
            4'd3:    c = 7'h4F;
            4'd4:    c = 7'h66;
            4'd5:    c = 7'h6D;
            4'd6:    c = 7'h7D;
            4'd7:    c = 7'h07;
            4'd8:    c = 7'h7F;
            4'd9:    c = 7'h6F;
            default: c = 7'h00;
        endcase
        return c;
    endfunction

    assign tens = (held_q >= 4'd10);
    assign ones = tens ? (held_q - 4'd10) : held_q;

    // Wrap compares against held, so idle gaps between 15 and 0 still count.
    assign wrap_hit = count_valid && (held_q == 4'hF) && (count_in == 4'h0);

    always_comb begin
        held_d       = count_valid ? count_in : held_q;
        wrap_pulse_d = wrap_hit;
        wrap_cnt_d   = wrap_cnt_q;
        if (wrap_hit && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end

        state_d = state_q;
        presc_d = '0;
        case (state_q)
            SHOW_ONES: begin
                if (presc_q == PRESC_LAST) state_d = BLANK_A;
                else                       presc_d = presc_q + 1'b1;
            end
            BLANK_A:   state_d = SHOW_TENS;
            SHOW_TENS: begin
                if (presc_q == PRESC_LAST) state_d = BLANK_B;
                else                       presc_d = presc_q + 1'b1;
            end
            BLANK_B:   state_d = SHOW_ONES;
            default:   state_d = SHOW_ONES;
        endcase

        an_hi  = 2'b00;
        seg_hi = 7'h00;
        case (state_q)
            SHOW_ONES: begin
                an_hi  = 2'b01;
                seg_hi = seg_code(ones);
            end
            SHOW_TENS: begin
                an_hi  = 2'b10;
                seg_hi = seg_code({3'b000, tens});
`ifdef LEADING_ZERO_BLANK_EN
                if (!tens) begin
                    an_hi  = 2'b00;
                    seg_hi = 7'h00;
                end
`else
`endif
            end
            default: begin
                an_hi  = 2'b00;
                seg_hi = 7'h00;
            end
        endcase

        seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_d  = SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= SHOW_ONES;
            presc_q      <= '0;
            held_q       <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            held_q       <= held_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;

endmodule
